// File: rtl/mips_pkg.sv
// Shared types for the MIPS memory-port arbiter: word/byte types, FSM and
// requester encodings, and the registered access descriptor.
package mips_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;
  typedef enum logic {REQ_FETCH, REQ_DATA} req_id_e;

  localparam int MAX_MEM_LAT = 7;
  localparam int LAT_W       = $clog2(MAX_MEM_LAT + 1);

  // Access latched at grant time; the address is already word-aligned.
  typedef struct packed {
    word_t   addr;
    logic    we;
    req_id_e owner;
  } access_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational requester picker for mem_port_arbiter. ARB_ROUND_ROBIN_EN
// selects round-robin on contention; otherwise data has fixed priority.
module mem_arb_pick
  import mips_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic halted,
  input  logic last_data,
  output logic gnt_valid,
  output logic gnt_data
);

  logic fetch_ok;

  assign fetch_ok = if_req & ~halted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    gnt_valid = fetch_ok | d_req;
    gnt_data  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && fetch_ok) begin
      gnt_data = ~last_data;
    end else if (d_req) begin
      gnt_data = 1'b1;
    end
`else
    if (d_req) begin
      gnt_data = 1'b1;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_data;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-laned memory port between fetch and load/store requesters.
// ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: data priority).
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in [0:3],
  input  logic [7:0]  mem_data_out [0:3],
  output logic        mem_write_en,
  output logic        busy,
  output logic        misalign_err
);

  arb_state_e           state, state_next;
  access_t              acc;
  logic [LAT_W-1:0]     cnt;
  logic                 pick_valid, pick_data;
  logic                 grant;
  logic                 last_data;
  word_t                req_addr;
  word_t                rd_word;

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .halted    (halted),
    .last_data (last_data),
    .gnt_valid (pick_valid),
    .gnt_data  (pick_data)
  );

  assign req_addr = pick_data ? d_addr : if_addr;
  assign rd_word  = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  assign mem_addr = acc.addr;
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant        = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    mem_write_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant      = 1'b1;
          d_gnt      = pick_data;
          if_gnt     = ~pick_data;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Store strobe only on the first WAIT cycle, while cnt is still full.
        mem_write_en = acc.we && (cnt == LAT_W'(MEM_LAT));
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        d_rvalid   = (acc.owner == REQ_DATA);
        if_rvalid  = (acc.owner == REQ_FETCH);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the store-lane registers are outputs that must read 0 in reset, so
  // the small array is reset element by element rather than left undefined.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc          <= '0;
      cnt          <= '0;
      misalign_err <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_data_in[i] <= '0;
      end
    end else if (grant) begin
      acc.addr  <= word_align(req_addr);
      acc.we    <= pick_data & d_we;
      acc.owner <= pick_data ? REQ_DATA : REQ_FETCH;
      cnt       <= LAT_W'(MEM_LAT);
      if (req_addr[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
      // Big-endian lane order: lane 0 carries the most significant byte.
      if (pick_data && d_we) begin
        for (int i = 0; i < 4; i++) begin
          mem_data_in[i] <= d_wdata[31-8*i -: 8];
        end
      end
    end else if (state == WAIT) begin
      if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end else if (acc.owner == REQ_DATA) begin
        d_rdata <= acc.we ? '0 : rd_word;
      end else begin
        if_rdata <= rd_word;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_data <= 1'b0;
    end else if (grant) begin
      last_data <= pick_data;
    end
  end
`else
  assign last_data = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT = 1): per-cycle vector
// table for load/store/fetch, then directed contention, halt, misalign, reset.
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata, mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_write_en, busy, misalign_err;

  word_t       mem [0:63];
  word_t       rd_q;

  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted       (halted),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  // One-cycle registered-read memory model; contents reload while in reset.
  always @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[0]  <= 32'hCAFE_F00D;
      mem[4]  <= 32'hDEAD_BEEF;
      mem[16] <= 32'h0102_0304;
      rd_q    <= '0;
    end else begin
      if (mem_write_en)
        mem[mem_addr[7:2]] <= {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
      rd_q <= mem[mem_addr[7:2]];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = rd_q[31-8*i -: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic  if_req;
    word_t if_addr;
    logic  d_req;
    logic  d_we;
    word_t d_addr;
    word_t d_wdata;
    logic  e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_busy, e_mem_we;
    word_t e_mem_addr, e_if_rdata, e_d_rdata;
  } vec_t;

  function automatic vec_t row(input logic ir, input word_t ia, input logic dr, input logic dw,
                               input word_t da, input word_t wd, input logic [5:0] flags,
                               input word_t ma, input word_t ird, input word_t drd);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da;  v.d_wdata = wd;
    {v.e_if_gnt, v.e_d_gnt, v.e_if_rvalid, v.e_d_rvalid, v.e_busy, v.e_mem_we} = flags;
    v.e_mem_addr = ma;  v.e_if_rdata = ird;  v.e_d_rdata = drd;
    return v;
  endfunction

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0;  d_addr = '0;  d_wdata = '0;
  endtask

  // Single access: request for one cycle, then count cycles to rvalid.
  task automatic run_access(input logic is_data, input logic we, input word_t addr,
                            input word_t wdata, output int lat);
    lat = -1;
    @(negedge clk);
    if (is_data) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    #1 check("acc_gnt", is_data ? d_gnt : if_gnt, 1);
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (is_data ? d_rvalid : if_rvalid) lat = c;
    end
    check("acc_latency", lat, LAT + 2);
  endtask

  vec_t vecs [0:13];
  logic seq [0:3];
  logic exp_seq [0:3];
  int   n_gnt;
  int   lat;

  initial begin
    // flags = {if_gnt, d_gnt, if_rvalid, d_rvalid, busy, mem_we}
    vecs[0]  = row(0, 0, 1, 0, 32'h10, 0,            6'b010000, 32'h00, 0, 0);
    vecs[1]  = row(0, 0, 0, 0, 0, 0,                 6'b000010, 32'h10, 0, 0);
    vecs[2]  = row(0, 0, 0, 0, 0, 0,                 6'b000010, 32'h10, 0, 0);
    vecs[3]  = row(0, 0, 0, 0, 0, 0,                 6'b000110, 32'h10, 0, 32'hDEADBEEF);
    vecs[4]  = row(0, 0, 0, 0, 0, 0,                 6'b000000, 32'h10, 0, 32'hDEADBEEF);
    vecs[5]  = row(0, 0, 1, 1, 32'h20, 32'h11223344, 6'b010000, 32'h10, 0, 32'hDEADBEEF);
    vecs[6]  = row(0, 0, 0, 0, 0, 0,                 6'b000011, 32'h20, 0, 32'hDEADBEEF);
    vecs[7]  = row(0, 0, 0, 0, 0, 0,                 6'b000010, 32'h20, 0, 32'hDEADBEEF);
    vecs[8]  = row(0, 0, 0, 0, 0, 0,                 6'b000110, 32'h20, 0, 0);
    vecs[9]  = row(1, 32'h40, 0, 0, 0, 0,            6'b100000, 32'h20, 0, 0);
    vecs[10] = row(0, 0, 0, 0, 0, 0,                 6'b000010, 32'h40, 0, 0);
    vecs[11] = row(0, 0, 0, 0, 0, 0,                 6'b000010, 32'h40, 0, 0);
    vecs[12] = row(0, 0, 0, 0, 0, 0,                 6'b001010, 32'h40, 32'h01020304, 0);
    vecs[13] = row(0, 0, 0, 0, 0, 0,                 6'b000000, 32'h40, 32'h01020304, 0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset state
    rst_b = 1'b0; halted = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_lanes", {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}, 0);
    check("rst_outs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_write_en, misalign_err}, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Load, store, back-to-back fetch
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req  = vecs[i].d_req;  d_we    = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      #1;
      check($sformatf("v%0d_if_gnt", i),    if_gnt,       vecs[i].e_if_gnt);
      check($sformatf("v%0d_d_gnt", i),     d_gnt,        vecs[i].e_d_gnt);
      check($sformatf("v%0d_if_rvalid", i), if_rvalid,    vecs[i].e_if_rvalid);
      check($sformatf("v%0d_d_rvalid", i),  d_rvalid,     vecs[i].e_d_rvalid);
      check($sformatf("v%0d_busy", i),      busy,         vecs[i].e_busy);
      check($sformatf("v%0d_mem_we", i),    mem_write_en, vecs[i].e_mem_we);
      check($sformatf("v%0d_mem_addr", i),  mem_addr,     vecs[i].e_mem_addr);
      check($sformatf("v%0d_if_rdata", i),  if_rdata,     vecs[i].e_if_rdata);
      check($sformatf("v%0d_d_rdata", i),   d_rdata,      vecs[i].e_d_rdata);
    end
    check("store_lanes", {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]},
          32'h11223344);
    check("store_mem", mem[8], 32'h11223344);
    check("no_misalign", misalign_err, 0);

    // Contention: both held for four grants
    n_gnt = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    d_req  = 1'b1; d_addr  = 32'h10; d_we = 1'b0;
    for (int c = 0; c < 60 && n_gnt < 4; c++) begin
      #1;
      if (if_gnt || d_gnt) begin
        seq[n_gnt] = d_gnt;
        n_gnt++;
      end
      @(negedge clk);
    end
    idle_inputs();
    check("contend_count", n_gnt, 4);
    for (int i = 0; i < 4; i++) check($sformatf("contend_gnt%0d_is_data", i), seq[i], exp_seq[i]);
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    #1 check("contend_drain", busy, 0);

    // Halt while a fetch is in WAIT
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    #1 check("halt_gnt", if_gnt, 1);
    @(negedge clk);
    @(negedge clk);
    halted = 1'b1;
    #1 check("halt_busy_wait", busy, 1);
    @(negedge clk);
    #1 check("halt_rvalid", if_rvalid, 1);
    check("halt_rdata", if_rdata, 32'h01020304);
    @(negedge clk);
    #1 check("halt_busy_low", busy, 0);
    n_gnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (if_gnt) n_gnt++;
      @(negedge clk);
      #1;
    end
    check("halt_no_gnt", n_gnt, 0);
    halted = 1'b0;
    idle_inputs();

    // Misaligned load, then an aligned one
    run_access(1'b1, 1'b0, 32'h23, 0, lat);
    check("mis_mem_addr", mem_addr, 32'h20);
    check("mis_rdata", d_rdata, 32'h11223344);
    check("mis_err", misalign_err, 1);
    run_access(1'b1, 1'b0, 32'h10, 0, lat);
    check("mis_sticky", misalign_err, 1);
    check("mis_next_rdata", d_rdata, 32'hDEADBEEF);

    // Reset mid-WAIT
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    #1 check("rstw_gnt", if_gnt, 1);
    @(negedge clk);
    idle_inputs();
    #1 rst_b = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_outs", {if_rvalid, d_rvalid, mem_write_en, misalign_err}, 0);
    check("rstw_addr", mem_addr, 0);
    check("rstw_rdata", if_rdata | d_rdata, 0);
    n_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 if (if_rvalid || d_rvalid) n_gnt++;
    end
    check("rstw_no_rvalid", n_gnt, 0);
    @(negedge clk);
    rst_b = 1'b1;
    run_access(1'b0, 1'b0, 32'h0, 0, lat);
    check("rstw_fresh_rdata", if_rdata, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
